// File: rtl/camera_init_sequencer.sv
// Power-up register-write sequencer for a camera I2C transmitter. It produces
// the nine-write startup phase vector and then relays one-at-a-time host writes.
module camera_init_sequencer #(
  parameter int unsigned PowerUpCycles   = 5000000,
  parameter int unsigned PulseCycles     = 16,
  parameter int unsigned WriteWaitCycles = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [17:0] startup_sequencer,
  output logic        send_special_i2c_command,
  output logic [7:0]  special_i2c_command_register,
  output logic [15:0] special_i2c_command_data,
  input  logic        special_cmd_req,
  input  logic [7:0]  special_cmd_register_in,
  input  logic [15:0] special_cmd_data_in,
  output logic        special_cmd_ack,
  output logic        special_cmd_busy,
  output logic        init_done,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] ST_PWRUP    = 3'd0;
  localparam logic [2:0] ST_WRITE    = 3'd1;
  localparam logic [2:0] ST_GAP      = 3'd2;
  localparam logic [2:0] ST_DONE     = 3'd3;
  localparam logic [2:0] ST_SPC_SEND = 3'd4;
  localparam logic [2:0] ST_SPC_WAIT = 3'd5;

  localparam logic [3:0] LAST_WRITE = 4'd8;

  // A zero-length phase still lasts one cycle, so every load is max(N,1)-1.
  localparam logic [31:0] PWRUP_LOAD = (PowerUpCycles   == 0) ? 32'd0 : 32'(PowerUpCycles - 1);
  localparam logic [31:0] PULSE_LOAD = (PulseCycles     == 0) ? 32'd0 : 32'(PulseCycles - 1);
  localparam logic [31:0] WAIT_LOAD  = (WriteWaitCycles == 0) ? 32'd0 : 32'(WriteWaitCycles - 1);

  logic [2:0]  state, state_d;
  logic [3:0]  k, k_d;
  logic [31:0] cnt, cnt_d;
  logic        accept;
  logic        cnt_zero;

  logic [17:0] seq_d;
  logic        send_d;
  logic        busy_d;
  logic        done_d;

  assign cnt_zero  = (cnt == 32'd0);
  assign dbg_state = state;

  // Host handshake: the host raises special_cmd_req with a stable payload and
  // holds both until it sees special_cmd_ack, which is a single-cycle pulse
  // issued only when the request is sampled in DONE. Requests seen in any
  // other state are neither acknowledged nor latched.
  assign accept = (state == ST_DONE) && special_cmd_req;

  always_comb begin
    state_d = state;
    k_d     = k;
    cnt_d   = cnt_zero ? cnt : cnt - 32'd1;
    case (state)
      ST_PWRUP: begin
        if (cnt_zero) begin
          state_d = ST_WRITE;
          k_d     = 4'd0;
          cnt_d   = PULSE_LOAD;
        end
      end
      ST_WRITE: begin
        if (cnt_zero) begin
          state_d = ST_GAP;
          cnt_d   = WAIT_LOAD;
        end
      end
      ST_GAP: begin
        if (cnt_zero) begin
          if (k == LAST_WRITE) begin
            state_d = ST_DONE;
            cnt_d   = 32'd0;
          end else begin
            state_d = ST_WRITE;
            k_d     = k + 4'd1;
            cnt_d   = PULSE_LOAD;
          end
        end
      end
      ST_DONE: begin
        cnt_d = 32'd0;
        if (accept) begin
          state_d = ST_SPC_SEND;
          cnt_d   = PULSE_LOAD;
        end
      end
      ST_SPC_SEND: begin
        if (cnt_zero) begin
          state_d = ST_SPC_WAIT;
          cnt_d   = WAIT_LOAD;
        end
      end
      ST_SPC_WAIT: begin
        if (cnt_zero) begin
          state_d = ST_DONE;
          cnt_d   = 32'd0;
        end
      end
      default: begin
        state_d = ST_PWRUP;
        k_d     = 4'd0;
        cnt_d   = PWRUP_LOAD;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered outputs line up
  // with the state register cycle for cycle.
  always_comb begin
    seq_d  = 18'd0;
    send_d = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      ST_WRITE: seq_d = 18'd1 << {k_d, 1'b0};
      ST_GAP:   seq_d = 18'd2 << {k_d, 1'b0};
      ST_DONE: begin
        seq_d  = 18'h20000;
        done_d = 1'b1;
      end
      ST_SPC_SEND: begin
        seq_d  = 18'h20000;
        send_d = 1'b1;
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      ST_SPC_WAIT: begin
        seq_d  = 18'h20000;
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: seq_d = 18'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_PWRUP;
      k     <= 4'd0;
      cnt   <= PWRUP_LOAD;
    end else begin
      state <= state_d;
      k     <= k_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      startup_sequencer            <= 18'd0;
      send_special_i2c_command     <= 1'b0;
      special_cmd_ack              <= 1'b0;
      special_cmd_busy             <= 1'b0;
      init_done                    <= 1'b0;
      special_i2c_command_register <= 8'd0;
      special_i2c_command_data     <= 16'd0;
    end else begin
      startup_sequencer        <= seq_d;
      send_special_i2c_command <= send_d;
      special_cmd_ack          <= accept;
      special_cmd_busy         <= busy_d;
      init_done                <= done_d;
      if (accept) begin
        special_i2c_command_register <= special_cmd_register_in;
        special_i2c_command_data     <= special_cmd_data_in;
      end
    end
  end

endmodule

// File: tb/tb_camera_init_sequencer.sv
// Bench for camera_init_sequencer: a timeline model derived from phase lengths
// predicts every output each cycle, with directed and randomized host requests.
module tb_camera_init_sequencer;

  localparam int PU     = 10;
  localparam int PL     = 4;
  localparam int WW     = 20;
  localparam int SLOT   = PL + WW;
  localparam int DONE_T = PU + 9 * SLOT;

  logic        clk;
  logic        rst_n;
  logic [17:0] startup_sequencer;
  logic        send_special_i2c_command;
  logic [7:0]  special_i2c_command_register;
  logic [15:0] special_i2c_command_data;
  logic        special_cmd_req;
  logic [7:0]  special_cmd_register_in;
  logic [15:0] special_cmd_data_in;
  logic        special_cmd_ack;
  logic        special_cmd_busy;
  logic        init_done;
  logic [2:0]  dbg_state;

  camera_init_sequencer #(
    .PowerUpCycles  (PU),
    .PulseCycles    (PL),
    .WriteWaitCycles(WW)
  ) dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .startup_sequencer           (startup_sequencer),
    .send_special_i2c_command    (send_special_i2c_command),
    .special_i2c_command_register(special_i2c_command_register),
    .special_i2c_command_data    (special_i2c_command_data),
    .special_cmd_req             (special_cmd_req),
    .special_cmd_register_in     (special_cmd_register_in),
    .special_cmd_data_in         (special_cmd_data_in),
    .special_cmd_ack             (special_cmd_ack),
    .special_cmd_busy            (special_cmd_busy),
    .init_done                   (init_done),
    .dbg_state                   (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          compared;
  int          mismatched;
  int          t;
  int          spc_start;
  logic [7:0]  exp_reg;
  logic [15:0] exp_data;
  logic [17:0] prev_seq;
  int          even_rises;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] model_seq(input int c);
    int p;
    int kk;
    logic [17:0] one;
    one = 18'd1;
    if (c < PU) return 18'd0;
    if (c < DONE_T) begin
      p  = c - PU;
      kk = p / SLOT;
      if ((p % SLOT) < PL) return one << (2 * kk);
      return one << (2 * kk + 1);
    end
    return 18'h20000;
  endfunction

  function automatic bit busy_at(input int c);
    return (spc_start >= 0) && (c >= spc_start) && (c < spc_start + SLOT);
  endfunction

  task automatic check_outputs();
    if (!rst_n) begin
      check("rst_seq",  {14'd0, startup_sequencer}, 32'd0);
      check("rst_send", {31'd0, send_special_i2c_command}, 32'd0);
      check("rst_ack",  {31'd0, special_cmd_ack}, 32'd0);
      check("rst_busy", {31'd0, special_cmd_busy}, 32'd0);
      check("rst_done", {31'd0, init_done}, 32'd0);
      check("rst_reg",  {24'd0, special_i2c_command_register}, 32'd0);
      check("rst_data", {16'd0, special_i2c_command_data}, 32'd0);
    end else begin
      check("seq",  {14'd0, startup_sequencer}, {14'd0, model_seq(t)});
      check("send", {31'd0, send_special_i2c_command},
            {31'd0, (spc_start >= 0 && t >= spc_start && t < spc_start + PL)});
      check("ack",  {31'd0, special_cmd_ack}, {31'd0, (spc_start >= 0 && t == spc_start)});
      check("busy", {31'd0, special_cmd_busy}, {31'd0, busy_at(t)});
      check("done", {31'd0, init_done}, {31'd0, (t >= DONE_T)});
      check("reg",  {24'd0, special_i2c_command_register}, {24'd0, exp_reg});
      check("data", {16'd0, special_i2c_command_data}, {16'd0, exp_data});
    end
    check("onehot0", {31'd0, $onehot0(startup_sequencer)}, 32'd1);
    check("send_vs_even",
          {31'd0, (send_special_i2c_command && ((startup_sequencer & 18'h15555) != 18'd0))}, 32'd0);
  endtask

  task automatic step();
    logic        req_s;
    logic        rst_s;
    logic [7:0]  reg_s;
    logic [15:0] data_s;
    req_s  = special_cmd_req;
    rst_s  = rst_n;
    reg_s  = special_cmd_register_in;
    data_s = special_cmd_data_in;
    @(posedge clk);
    #1;
    if (rst_s) begin
      t++;
      if ((t - 1) >= DONE_T && !busy_at(t - 1) && req_s) begin
        spc_start = t;
        exp_reg   = reg_s;
        exp_data  = data_s;
      end
    end
    check_outputs();
    even_rises += $countones(startup_sequencer & ~prev_seq & 18'h15555);
    prev_seq = startup_sequencer;
  endtask

  task automatic idle(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        special_cmd_register_in = 8'($urandom);
        special_cmd_data_in     = 16'($urandom);
      end
      step();
    end
  endtask

  task automatic assert_reset();
    #2;
    rst_n = 1'b0;
    #1;
    t         = 0;
    spc_start = -1;
    exp_reg   = 8'd0;
    exp_data  = 16'd0;
    check_outputs();
  endtask

  task automatic release_reset();
    #2;
    rst_n      = 1'b1;
    t          = 0;
    prev_seq   = 18'd0;
    even_rises = 0;
  endtask

  task automatic wait_ack(input int budget);
    int n;
    n = 0;
    while (!special_cmd_ack && n < budget) begin
      step();
      n++;
    end
    check("ack_seen", {31'd0, special_cmd_ack}, 32'd1);
  endtask

  int sc;
  int bc;

  initial begin
    compared   = 0;
    mismatched = 0;
    t          = 0;
    spc_start  = -1;
    exp_reg    = 8'd0;
    exp_data   = 16'd0;
    prev_seq   = 18'd0;
    even_rises = 0;
    rst_n                   = 1'b0;
    special_cmd_req         = 1'b0;
    special_cmd_register_in = 8'($urandom);
    special_cmd_data_in     = 16'($urandom);

    // Reset state, then the full startup run with no host requests.
    #2;
    check_outputs();
    idle(3, 1'b1);
    release_reset();
    idle(DONE_T + 10, 1'b1);
    check("even_rises", even_rises, 32'd9);
    check("t_done", {31'd0, init_done}, 32'd1);

    // Directed special write 0x35/0x1234, payload inputs scrambled while busy.
    special_cmd_register_in = 8'h35;
    special_cmd_data_in     = 16'h1234;
    special_cmd_req         = 1'b1;
    wait_ack(10);
    special_cmd_req = 1'b0;
    check("ack_reg",  {24'd0, special_i2c_command_register}, 32'h35);
    check("ack_data", {16'd0, special_i2c_command_data}, 32'h1234);
    sc = send_special_i2c_command ? 1 : 0;
    bc = special_cmd_busy ? 1 : 0;
    for (int i = 0; i < 30; i++) begin
      special_cmd_register_in = 8'($urandom);
      special_cmd_data_in     = 16'($urandom);
      step();
      sc += send_special_i2c_command ? 1 : 0;
      bc += special_cmd_busy ? 1 : 0;
    end
    check("send_len", sc, PL);
    check("busy_len", bc, SLOT);
    check("hold_reg",  {24'd0, special_i2c_command_register}, 32'h35);
    check("hold_data", {16'd0, special_i2c_command_data}, 32'h1234);

    // Randomized back-to-back and spaced host requests.
    for (int j = 0; j < 5; j++) begin
      idle(int'($urandom_range(0, 6)), 1'b1);
      special_cmd_register_in = 8'($urandom);
      special_cmd_data_in     = 16'($urandom);
      special_cmd_req         = 1'b1;
      wait_ack(SLOT + 10);
      special_cmd_req = 1'b0;
      idle(int'($urandom_range(2, SLOT + 4)), 1'b1);
    end

    // Request held from reset release: ignored until DONE, not re-acked while busy.
    assert_reset();
    idle(2, 1'b1);
    special_cmd_req = 1'b1;
    release_reset();
    wait_ack(DONE_T + 10);
    check("ack_time", t, DONE_T + 1);
    idle(15, 1'b1);
    special_cmd_req = 1'b0;
    idle(20, 1'b1);

    // Reset during WRITE(3): outputs drop at once, power-up restarts cleanly.
    assert_reset();
    idle(2, 1'b0);
    release_reset();
    idle(PU + 3 * SLOT + 1, 1'b1);
    check("in_write3", {14'd0, startup_sequencer}, 32'h40);
    assert_reset();
    idle(2, 1'b1);
    release_reset();
    idle(PU, 1'b1);
    check("bit0_again", {14'd0, startup_sequencer}, 32'h1);

    // Reset in the middle of a special write, at a random point.
    idle(DONE_T - PU + 2, 1'b1);
    special_cmd_req = 1'b1;
    wait_ack(10);
    special_cmd_req = 1'b0;
    idle(int'($urandom_range(1, SLOT - 2)), 1'b1);
    assert_reset();
    idle(2, 1'b1);
    release_reset();
    idle(PU + 2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/camera_init_sequencer.md
CAMERA_INIT_SEQUENCER -- requirements
Module: camera_init_sequencer

Interface
REQ-001 The block SHALL have parameter PowerUpCycles, default 5000000, cycles from reset release to the first write (100 ms at 50 MHz).
REQ-002 The block SHALL have parameter PulseCycles, default 16, cycles each write-request bit is held high.
REQ-003 The block SHALL have parameter WriteWaitCycles, default 1000000, idle cycles after each write pulse; this exceeds one full I2C transaction.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port startup_sequencer, output, 18 bits: phase vector to the I2C transmitter.
REQ-007 The block SHALL have port send_special_i2c_command, output, 1 bit: special-write request level.
REQ-008 The block SHALL have ports special_i2c_command_register (output, 8 bits) and special_i2c_command_data (output, 16 bits): latched special-write payload.
REQ-009 The block SHALL have ports special_cmd_req (input, 1 bit), special_cmd_register_in (input, 8 bits) and special_cmd_data_in (input, 16 bits): host special-write request and payload.
REQ-010 The block SHALL have ports special_cmd_ack (output, 1 bit) and special_cmd_busy (output, 1 bit): request accepted, and special write in progress.
REQ-011 The block SHALL have port init_done, output, 1 bit: all nine startup writes have completed.

Function
REQ-012 The block SHALL implement the states PWRUP, WRITE(k), GAP(k), DONE, SPC_SEND and SPC_WAIT, with k = 0..8, driven by a single 32-bit down-counter.
REQ-013 PWRUP SHALL hold startup_sequencer at 0 for PowerUpCycles cycles, then go to WRITE(0).
REQ-014 WRITE(k) SHALL drive exactly bit 2k of startup_sequencer high for PulseCycles cycles, then go to GAP(k).
REQ-015 GAP(k), k<8, SHALL drive exactly bit 2k+1 high for WriteWaitCycles cycles, then go to WRITE(k+1).
REQ-016 GAP(8) SHALL drive bit 17 high for WriteWaitCycles cycles, then go to DONE.
REQ-017 At most one startup_sequencer bit SHALL be high in any cycle.
REQ-018 Every even bit SHALL return low for at least one cycle before the next even bit rises, so the transmitter sees a fresh rising edge for each write.
REQ-019 In DONE, startup_sequencer SHALL hold bit 17 high only, init_done SHALL be 1, and init_done SHALL remain 1 until reset.
REQ-020 special_cmd_req sampled high in DONE SHALL latch special_cmd_register_in and special_cmd_data_in into the output payload registers, pulse special_cmd_ack high for exactly one cycle, and enter SPC_SEND on the next cycle.
REQ-021 special_cmd_req asserted in any state other than DONE SHALL be ignored (no ack, no latch); the host holds the request until it sees ack.
REQ-022 SPC_SEND SHALL hold send_special_i2c_command high for PulseCycles cycles, then enter SPC_WAIT.
REQ-023 SPC_WAIT SHALL hold send_special_i2c_command low for WriteWaitCycles cycles, then return to DONE.
REQ-024 special_cmd_busy SHALL be 1 exactly in SPC_SEND and SPC_WAIT.
REQ-025 While special_cmd_busy is 1, the payload registers SHALL be stable.
REQ-026 send_special_i2c_command and any even startup_sequencer bit SHALL never be high in the same cycle.
REQ-027 The counter SHALL load (N-1) on state entry and transition when it reaches 0; a parameter value of 0 SHALL be treated as 1.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 While rst_n is low, all outputs SHALL be 0, the state SHALL be PWRUP and the counter SHALL be PowerUpCycles-1.
REQ-030 Assertion of rst_n SHALL take effect immediately; release SHALL be recognised at the next clk edge.
REQ-031 Reset mid-sequence or mid special write SHALL abort it, drop every output to 0 immediately, and restart from PWRUP with no partial pulse resumed.

Verification (PowerUpCycles=10, PulseCycles=4, WriteWaitCycles=20)
REQ-032 Release reset, hold special_cmd_req=0 -> bit0 rises at cycle 10 and is high 4 cycles; bit1 high 20 cycles; the pattern repeats through bit17; init_done rises at cycle 10+9*24=226.
REQ-033 Over the whole run of REQ-032 -> the one-hot/zero check on startup_sequencer holds every cycle, and exactly 9 even-bit rising edges occur.
REQ-034 In DONE, pulse special_cmd_req with register 0x35 and data 0x1234 -> ack high for 1 cycle; the payload outputs read 0x35/0x1234; send high 4 cycles; busy high 24 cycles; then back to DONE.
REQ-035 Hold special_cmd_req=1 from reset release -> no ack before init_done; one ack the cycle after init_done rises; no second ack while busy.
REQ-036 Assert rst_n low during WRITE(3) -> all outputs are 0 asynchronously; after release, bit0 reappears 10 cycles later.
REQ-037 Change the payload inputs while busy -> the payload outputs are unchanged until the next accepted request.
